// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter and the schedulers
// that reuse its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// last_grant, searched on a doubled request vector and reduced modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_valid
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;

  assign w_dbl     = {req, req};
  assign w_rot     = NUM_REQ'(w_dbl >> (int'(last_grant) + 1));
  assign any_valid = |req;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    winner  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        winner  = ID_WIDTH'((int'(last_grant) + 1 + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ
// valid/ready/last requesters; beats pass through with zero added latency.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic                          release_timeout
);

  state_e                r_state, w_next_state;
  logic [ID_WIDTH-1:0]   r_grant_id, r_last_grant, w_winner;
  logic [CNT_WIDTH-1:0]  r_beat_cnt, r_idle_cnt;
  logic                  r_release_timeout;
  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];
  logic w_any_valid, w_g_valid, w_g_last;
  logic w_grant, w_beat_release, w_idle_cycle, w_timeout;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rr_pick (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .any_valid  (w_any_valid)
  );

  assign w_g_valid      = req_valid[r_grant_id];
  assign w_g_last       = req_last[r_grant_id];
  assign w_grant        = (r_state == ST_IDLE) && w_any_valid && !fifo_full;
  assign w_beat_release = fifo_write_en &&
                          (w_g_last || (r_beat_cnt == CNT_WIDTH'(MAX_BURST - 1)));
  // Stalled cycles (fifo_full) neither advance nor clear the idle count.
  assign w_idle_cycle   = (r_state == ST_BURST) && !w_g_valid && !fifo_full;
  assign w_timeout      = w_idle_cycle && (r_idle_cnt == CNT_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_next_state = ST_BURST;
      ST_BURST: if (w_beat_release || w_timeout) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready       = '0;
    fifo_write_en   = 1'b0;
    fifo_write_data = '0;
    if (r_state == ST_BURST) begin
      req_ready[r_grant_id] = !fifo_full;
      fifo_write_en         = w_g_valid && !fifo_full;
      if (fifo_write_en) fifo_write_data = w_slice[r_grant_id];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments for all registered state so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rstn) begin
      r_grant_id        <= '0;
      r_last_grant      <= ID_WIDTH'(NUM_REQ - 1);
      r_beat_cnt        <= '0;
      r_idle_cnt        <= '0;
      r_release_timeout <= 1'b0;
    end else begin
      r_release_timeout <= w_timeout;
      if (w_grant) begin
        r_grant_id <= w_winner;
        r_beat_cnt <= '0;
        r_idle_cnt <= '0;
      end else if (fifo_write_en) begin
        r_idle_cnt <= '0;
        if (w_beat_release) begin
          r_last_grant <= r_grant_id;
          r_beat_cnt   <= '0;
        end else begin
          r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
        end
      end else if (w_idle_cycle) begin
        if (w_timeout) begin
          r_last_grant <= r_grant_id;
          r_idle_cnt   <= '0;
          r_beat_cnt   <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign grant_id        = r_grant_id;
  assign busy            = (r_state == ST_BURST);
  assign release_timeout = r_release_timeout;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: transaction-level reference model feeds a
// scoreboard that a negedge monitor drains; directed scenarios plus random traffic.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int DW  = 8;
  localparam int MB  = 8;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            fifo_full, fifo_write_en;
  logic [DW-1:0]   fifo_write_data;
  logic [IDW-1:0]  grant_id;
  logic            busy, release_timeout;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .grant_id        (grant_id),
    .busy            (busy),
    .release_timeout (release_timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic           busy;
    logic [IDW-1:0] gid;
    logic [N-1:0]   rdy;
    logic           rto;
    logic           we;
    logic [DW-1:0]  data;
  } ctl_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } wr_t;

  ctl_t ctl_q[$];
  wr_t  wr_q[$];

  // Reference model: owner = -1 means nobody holds the port.
  int m_owner, m_gid, m_beats, m_idle, m_last;
  bit m_rto;

  task automatic model_reset();
    m_owner = -1; m_gid = 0; m_beats = 0; m_idle = 0; m_last = N - 1; m_rto = 0;
  endtask

  // Drive one clock cycle of inputs, queue what the DUT must show, advance the model.
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic [N*DW-1:0] d, input logic full,
                       output logic [N-1:0] rdy);
    ctl_t e;
    int n_owner, n_gid, n_beats, n_idle, n_last, c;
    bit n_rto;
    req_valid = v; req_last = l; req_data = d; fifo_full = full;
    e.busy = (m_owner >= 0);
    e.gid  = IDW'(m_gid);
    e.rto  = m_rto;
    e.rdy  = '0;
    e.we   = 1'b0;
    e.data = '0;
    if (m_owner >= 0) begin
      e.rdy[m_owner] = !full;
      e.we = v[m_owner] && !full;
      if (e.we) e.data = d[m_owner*DW +: DW];
    end
    ctl_q.push_back(e);
    if (e.we) wr_q.push_back('{IDW'(m_owner), e.data});
    rdy = e.rdy;

    n_owner = m_owner; n_gid = m_gid; n_beats = m_beats;
    n_idle = m_idle; n_last = m_last; n_rto = 0;
    if (m_owner < 0) begin
      if (v != '0 && !full) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (v[c] && n_owner < 0) begin
            n_owner = c; n_gid = c; n_beats = 0; n_idle = 0;
          end
        end
      end
    end else if (e.we) begin
      n_beats = m_beats + 1;
      n_idle  = 0;
      if (l[m_owner] || n_beats == MB) begin
        n_last = m_owner; n_owner = -1; n_beats = 0;
      end
    end else if (!full) begin
      n_idle = m_idle + 1;
      if (n_idle == TO) begin
        n_last = m_owner; n_owner = -1; n_rto = 1; n_idle = 0;
      end
    end

    @(posedge clk);
    if (rstn) begin
      m_owner = n_owner; m_gid = n_gid; m_beats = n_beats;
      m_idle = n_idle; m_last = n_last; m_rto = n_rto;
    end
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check("rst_ready", req_ready, '0);
    check("rst_we", fifo_write_en, 0);
    check("rst_data", fifo_write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout", release_timeout, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  ctl_t me;
  wr_t  mw;

  always @(negedge clk) begin
    if (ctl_q.size() > 0) begin
      me = ctl_q.pop_front();
      check("busy", busy, me.busy);
      check("grant_id", grant_id, me.gid);
      check("req_ready", req_ready, me.rdy);
      check("release_timeout", release_timeout, me.rto);
      check("write_en", fifo_write_en, me.we);
      check("write_data_out", fifo_write_data, me.data);
    end
    if (fifo_write_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data %0h expected no write at %0t",
                 fifo_write_data, $time);
      end else begin
        mw = wr_q.pop_front();
        check("sb_write_data", fifo_write_data, mw.data);
        check("sb_write_id", grant_id, mw.id);
      end
    end
  end

  logic [N-1:0]    v, l, rdy;
  logic [N*DW-1:0] d;
  logic            full;
  int idx, stall, rises, pulses, full_cnt;
  bit prev_busy, busy_seen;
  int rem[N], pause[N];
  logic [DW-1:0] cur[N];
  bit held[N];

  initial begin
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    rstn = 1'b1;
    model_reset();
    #2;
    do_reset();

    // Requester 0 alone: three beats A1..A3, last on A3.
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      v = (idx < 3) ? 4'b0001 : 4'b0000;
      l = (idx == 2) ? 4'b0001 : 4'b0000;
      d = '0;
      d[7:0] = 8'hA1 + 8'(idx);
      cycle(v, l, d, 1'b0, rdy);
      if (v[0] && rdy[0]) idx++;
    end
    check("t1_idle_after", busy, 0);

    // All requesters streaming without last: forced release every MAX_BURST beats.
    do_reset();
    prev_busy = 0; rises = 0;
    for (int c = 0; c < 45; c++) begin
      cycle(4'b1111, 4'b0000, {$urandom}, 1'b0, rdy);
      if (busy && !prev_busy) begin
        check("t2_grant_seq", grant_id, rises % 4);
        rises++;
      end
      prev_busy = busy;
    end
    check("t2_burst_count", rises, 5);

    // Requester 2, ten beats, FIFO full for two cycles after beat 3.
    do_reset();
    idx = 0; stall = 0;
    for (int c = 0; c < 16; c++) begin
      full = (idx == 3 && stall < 2);
      if (full) stall++;
      v = (idx < 10) ? 4'b0100 : 4'b0000;
      d = {$urandom};
      d[23:16] = 8'h30 + 8'(idx);
      cycle(v, 4'b0000, d, full, rdy);
      if (v[2] && rdy[2]) idx++;
    end

    // Grantee 1 goes quiet while requester 3 waits: timeout release.
    do_reset();
    cycle(4'b0010, 4'b0000, {$urandom}, 1'b0, rdy);
    cycle(4'b0010, 4'b0000, {$urandom}, 1'b0, rdy);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(4'b1000, 4'b0000, {$urandom}, 1'b0, rdy);
      if (release_timeout) pulses++;
    end
    check("t4_timeout_pulses", pulses, 1);
    check("t4_next_grant", grant_id, 3);
    check("t4_busy", busy, 1);

    // Reset in the middle of a burst from requester 2.
    do_reset();
    for (int c = 0; c < 5; c++) cycle(4'b0100, 4'b0000, {$urandom}, 1'b0, rdy);
    check("t5_write_before_reset", fifo_write_en, 1);
    do_reset();
    cycle(4'b0101, 4'b0000, {$urandom}, 1'b0, rdy);
    check("t5_grant_after_reset", grant_id, 0);
    check("t5_busy_after_reset", busy, 1);

    // FIFO full in IDLE blocks the grant.
    do_reset();
    busy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(4'b1111, 4'b0000, {$urandom}, 1'b1, rdy);
      busy_seen |= busy;
    end
    check("t6_no_grant_while_full", busy_seen, 0);
    cycle(4'b1111, 4'b0000, {$urandom}, 1'b0, rdy);
    check("t6_grant_after_full", grant_id, 0);
    check("t6_busy_after_full", busy, 1);

    // Random traffic: bursts of 1..11 beats, valid gaps, long pauses, FIFO stalls.
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; pause[i] = 0; held[i] = 0; cur[i] = '0;
    end
    full_cnt = 0;
    for (int it = 0; it < 3000; it++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 7) == 0) begin
          rem[i] = int'($urandom_range(1, 11));
          cur[i] = DW'($urandom);
        end
        if (pause[i] > 0) pause[i]--;
        else if (!held[i] && $urandom_range(0, 63) == 0) pause[i] = int'($urandom_range(16, 24));
        v[i] = (rem[i] > 0) && (held[i] || (pause[i] == 0 && $urandom_range(0, 3) != 0));
        l[i] = v[i] && (rem[i] == 1);
        d[i*DW +: DW] = v[i] ? cur[i] : DW'($urandom);
      end
      if (full_cnt > 0) begin
        full = 1'b1;
        full_cnt--;
      end else begin
        full = 1'b0;
        if ($urandom_range(0, 9) == 0) full_cnt = int'($urandom_range(1, 5));
      end
      cycle(v, l, d, full, rdy);
      for (int i = 0; i < N; i++) begin
        if (v[i] && rdy[i]) begin
          rem[i]--;
          cur[i] = DW'($urandom);
          held[i] = 0;
        end else begin
          held[i] = v[i];
        end
      end
    end

    for (int c = 0; c < 40; c++) cycle(4'b0000, 4'b0000, '0, 1'b0, rdy);
    @(negedge clk);
    #1;
    check("scoreboard_drained", wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
